// File: rtl/keypad_move_event_if.sv
// keypad_move_event_if: valid/ready move-event channel from keypad_move_event to game logic
interface keypad_move_event_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_col;
    logic       evt_pop;
    modport master (output evt_valid, evt_col, evt_pop, input evt_ready);
    modport slave  (input evt_valid, evt_col, evt_pop, output evt_ready);
endinterface

// File: rtl/keypad_move_event.sv
// keypad_move_event: debounces keypad presses into one-per-press column move events (KEYPAD_EVT_FIFO_EN selects a 4-entry event FIFO)
module keypad_move_event #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NUM_COLS        = 7
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  key_held,
    input  logic [3:0]            key_code,
    input  logic                  pop_mode,
    input  logic                  game_lock,
    keypad_move_event_if.master   evt,
    output logic                  evt_overflow,
    output logic                  busy
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] DEB_PRESS   = 2'd1;
    localparam logic [1:0] HELD        = 2'd2;
    localparam logic [1:0] DEB_RELEASE = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]    code_q, code_d;
    logic          code_ok, gen, ovf_q, ovf_d;
    logic [2:0]    gen_col;

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    assign code_ok = (code_q != 4'd0) && (int'(code_q) <= NUM_COLS);
    assign gen_col = 3'(code_q - 4'd1);
    assign busy    = state_q != IDLE;
    assign evt_overflow = ovf_q;

    // debounce FSM; gen marks the edge a stable press becomes a move
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        gen     = 1'b0;
        case (state_q)
            IDLE: if (key_held && !game_lock) begin
                state_d = DEB_PRESS;
                cnt_d   = '0;
                code_d  = key_code;
            end
            DEB_PRESS: if (!key_held || key_code != code_q) state_d = IDLE;
                else if (cnt_q == CNT_MAX) begin
                    state_d = HELD;
                    gen     = code_ok && !game_lock;
                end else cnt_d = cnt_inc;
            HELD: if (!key_held) begin
                state_d = DEB_RELEASE;
                cnt_d   = '0;
            end
            default: if (key_held) state_d = HELD;
                else if (cnt_q == CNT_MAX) state_d = IDLE;
                else cnt_d = cnt_inc;
        endcase
    end

    // FSM, counter and captured code registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef KEYPAD_EVT_FIFO_EN
    logic [2:0] fcol_q [4];
    logic       fpop_q [4];
    logic [1:0] rd_q, wr_q;
    logic [2:0] fcnt_q, fcnt_d;
    logic       push, pop;

    assign pop    = (fcnt_q != 3'd0) && evt.evt_ready;
    assign push   = gen && ((fcnt_q != 3'd4) || pop);
    assign ovf_d  = gen && !push;
    assign fcnt_d = fcnt_q + 3'(push) - 3'(pop);
    assign evt.evt_valid = fcnt_q != 3'd0;
    assign evt.evt_col   = fcol_q[rd_q];
    assign evt.evt_pop   = fpop_q[rd_q];

    // FIFO storage; a full FIFO accepts a push when the head leaves on the same edge
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < 4; i++) begin
                fcol_q[i] <= '0;
                fpop_q[i] <= 1'b0;
            end
            rd_q   <= '0;
            wr_q   <= '0;
            fcnt_q <= '0;
        end else begin
            if (push) begin
                fcol_q[wr_q] <= gen_col;
                fpop_q[wr_q] <= pop_mode;
            end
            wr_q   <= wr_q + 2'(push);
            rd_q   <= rd_q + 2'(pop);
            fcnt_q <= fcnt_d;
        end
    end
`else
    logic       valid_q, valid_d, pop_q, pop_d, load;
    logic [2:0] col_q, col_d;

    assign load  = gen && (!valid_q || evt.evt_ready);
    assign ovf_d = gen && !load;
    assign evt.evt_valid = valid_q;
    assign evt.evt_col   = col_q;
    assign evt.evt_pop   = pop_q;

    // holding register: a new event replaces only an empty or departing one
    always_comb begin
        valid_d = load ? 1'b1 : valid_q && !evt.evt_ready;
        col_d   = load ? gen_col : col_q;
        pop_d   = load ? pop_mode : pop_q;
    end

    // holding register state
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            valid_q <= 1'b0;
            col_q   <= '0;
            pop_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            col_q   <= col_d;
            pop_q   <= pop_d;
        end
    end
`endif
endmodule

// File: doc/keypad_move_event.md
Name: keypad_move_event

Overview:
- Sits between the PMOD keypad decoder and the connect4 game logic.
- Converts the decoder's raw scanned key level and code into clean, debounced, one-per-press move events: column 0-6 plus a pop/drop flag.
- Delivers each event over a valid/ready handshake, so game logic consumes a move exactly once regardless of hold time or contact bounce.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles required to accept a press or a release (10 ms at 100 MHz); must be >= 2
NUM_COLS, 7, number of legal columns; key codes 1..NUM_COLS map to columns 0..NUM_COLS-1

Ports:
clk  input  1  system clock, 100 MHz
clr_n  input  1  asynchronous active-low reset
key_held  input  1  level from decoder; 1 while any key is physically down
key_code  input  4  decoder key code, meaningful while key_held=1
pop_mode  input  1  1 = pop move, 0 = drop move; sampled when an event is generated
game_lock  input  1  1 = suppress new events (win screen, reset sequence)
evt_ready  input  1  game logic accepts the event on this edge
evt_valid  output  1  event available
evt_col  output  3  column of the event, 0..NUM_COLS-1
evt_pop  output  1  pop flag of the event
evt_overflow  output  1  one-cycle pulse: an event was lost
busy  output  1  1 whenever FSM is not in IDLE

Behaviour:
- Reset (clr_n=0, asynchronous): FSM to IDLE, counter 0, evt_valid/evt_col/evt_pop/evt_overflow/busy all 0, stored code 0. Reset mid-debounce discards the press. After release, a still-held key restarts from IDLE.
- Counter width is clog2(DEBOUNCE_CYCLES); it never wraps. It saturates at its terminal value DEBOUNCE_CYCLES-1.
- FSM IDLE:
  - key_held=1 and game_lock=0 -> DEB_PRESS; capture key_code; counter=0.
  - Otherwise stay in IDLE.
- FSM DEB_PRESS:
  - key_held=0 or key_code differs from captured -> IDLE (bounce rejected, nothing emitted).
  - Counter reaches DEBOUNCE_CYCLES-1 with input still stable -> HELD. On that edge an event is generated if captured code is in 1..NUM_COLS and game_lock=0; col=code-1, pop=pop_mode on that edge.
  - Codes 0 and >NUM_COLS generate no event but still enter HELD.
- FSM HELD:
  - key_held=0 -> DEB_RELEASE; counter=0.
  - Code changes while held are ignored: no second event until a full release.
- FSM DEB_RELEASE:
  - key_held=1 -> HELD.
  - key_held=0 for DEBOUNCE_CYCLES consecutive cycles -> IDLE.
- Latency: with key_held=1 and a stable code first sampled at edge E0, evt_valid is 1 after edge E0+DEBOUNCE_CYCLES.
- Handshake:
  - evt_col/evt_pop are stable while evt_valid=1.
  - Transfer occurs on an edge with evt_valid=1 and evt_ready=1.
  - evt_valid drops after transfer unless another event is pending.
  - evt_ready is ignored when evt_valid=0.
- Output holding register (default build):
  - New event, evt_valid=0 -> loaded.
  - New event, evt_valid=1 and evt_ready=1 on the same edge -> old event transferred, new one loaded, no overflow.
  - New event, evt_valid=1 and evt_ready=0 -> new event dropped, evt_overflow=1 for exactly one cycle, held event unchanged.
- game_lock does not clear an already pending event. game_lock rising during DEB_PRESS suppresses the event; the FSM still requires a full release.

Optional Feature:
KEYPAD_EVT_FIFO_EN
- Defined: the holding register is replaced by a 4-entry FIFO.
  - evt_valid = FIFO not empty; head is presented on evt_col/evt_pop.
  - Push and pop on the same edge are both honoured, including when the FIFO is full.
  - Push while full without pop -> event dropped, evt_overflow pulses for one cycle.
  - Reset empties the FIFO.
- Undefined: single holding register as described above; no FIFO storage.

Test Plan:
1. DEBOUNCE_CYCLES=4, pop_mode=0, evt_ready=1, key_code=3 with key_held=1 for 10 cycles -> exactly one evt_valid cycle 4 edges after first sample; evt_col=2, evt_pop=0; busy returns to 0 after 4 released cycles.
2. key_code=5: key_held high 2 cycles, low 1, high 8 -> single event evt_col=4, timed from the second rise; no event from the first burst.
3. key_code=9 held 8 cycles, then released -> no evt_valid; busy=1 throughout; IDLE 4 cycles after release.
4. evt_ready=0, press key 1 then key 6 (each fully released), pop_mode=1 -> evt_col=0, evt_pop=1 held; second press raises evt_overflow for 1 cycle. With KEYPAD_EVT_FIFO_EN, both events drain in order (0 then 5) once evt_ready=1, with no overflow.
5. clr_n pulsed low for 1 cycle during DEB_PRESS with key 2 still held -> all outputs 0 immediately; single event evt_col=1 appears 4 edges after reset release.
6. game_lock=1, press key 4 -> no event. game_lock rising during DEB_PRESS -> no event, FSM passes through HELD; next press after unlock emits normally.
